// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer: FSM states, default
// widths and the ALU opcode constants.
package alu_seq_pkg;

    localparam int DATA_W_DEF     = 6;
    localparam int REG_ADDR_W_DEF = 2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// Operand register file for the ALU sequencer: two asynchronous read ports,
// one synchronous write port, synchronous reset clearing every entry.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = REG_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];

    // One register per entry so the whole file can be cleared in one cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        // Clear on reset, otherwise take the write when addressed.
        always_ff @(posedge clk) begin
            if (reset) begin
                mem_reg[gi] <= '0;
            end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                mem_reg[gi] <= wr_data;
            end
        end
    end

    // Reads return the state before any write landing on this edge.
    assign rd_data_a = mem_reg[rd_addr_a];
    assign rd_data_b = mem_reg[rd_addr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 6-bit ALU: accepts one instruction at a time, drives
// the ALU operands from a small register file and writes the result back.
// Optional status outputs (zeroFlag, busy) are enabled by ALU_SEQ_STATUS_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instValid,
    output logic                  instReady,
    input  logic                  instLoad,
    input  logic [3:0]            instOp,
    input  logic [REG_ADDR_W-1:0] instRd,
    input  logic [REG_ADDR_W-1:0] instRs,
    input  logic [REG_ADDR_W-1:0] instRt,
    input  logic [DATA_W-1:0]     instImm,
    input  logic                  instCarryIn,
    input  logic                  instUseCarry,
    output logic [DATA_W-1:0]     a,
    output logic [DATA_W-1:0]     b,
    output logic                  carryIn,
    output logic [3:0]            aluOp,
    input  logic [DATA_W-1:0]     result,
    input  logic                  carryOut,
    output logic                  doneValid,
    output logic [DATA_W-1:0]     doneData,
`ifdef ALU_SEQ_STATUS_EN
    output logic                  zeroFlag,
    output logic                  busy,
`endif
    output logic                  carryFlag
);

    state_t                  state_reg;
    logic [REG_ADDR_W-1:0]   rd_reg;
    logic                    load_reg;
    logic                    cap_carry_reg;
    logic [DATA_W-1:0]       rs_data;
    logic [DATA_W-1:0]       rt_data;
    logic                    wr_en;

    assign instReady = (state_reg == IDLE);
    assign wr_en     = (state_reg == WB);

`ifdef ALU_SEQ_STATUS_EN
    assign busy = (state_reg != IDLE);
`endif

    // doneData doubles as the captured value, so it is also the write data.
    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (instRs),
        .rd_data_a (rs_data),
        .rd_addr_b (instRt),
        .rd_data_b (rt_data),
        .wr_en     (wr_en),
        .wr_addr   (rd_reg),
        .wr_data   (doneData)
    );

    // Sequencer FSM with all ALU-facing and completion outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            a             <= '0;
            b             <= '0;
            carryIn       <= 1'b0;
            aluOp         <= '0;
            carryFlag     <= 1'b0;
            doneValid     <= 1'b0;
            doneData      <= '0;
            rd_reg        <= '0;
            load_reg      <= 1'b0;
            cap_carry_reg <= 1'b0;
`ifdef ALU_SEQ_STATUS_EN
            zeroFlag      <= 1'b0;
`endif
        end else begin
            doneValid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (instValid) begin
                        rd_reg   <= instRd;
                        load_reg <= instLoad;
                        if (instLoad) begin
                            // Loads skip the ALU entirely; its ports keep their values.
                            doneData  <= instImm;
                            doneValid <= 1'b1;
                            state_reg <= WB;
                        end else begin
                            a         <= rs_data;
                            b         <= rt_data;
                            aluOp     <= instOp;
                            carryIn   <= instUseCarry ? carryFlag : instCarryIn;
                            state_reg <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    doneData      <= result;
                    cap_carry_reg <= carryOut;
                    doneValid     <= 1'b1;
                    state_reg     <= WB;
                end
                WB: begin
                    if (!load_reg) begin
                        carryFlag <= cap_carry_reg;
`ifdef ALU_SEQ_STATUS_EN
                        zeroFlag  <= (doneData == '0);
`endif
                    end
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
